fetch_unit: RTL and testbench

Instruction fetch stage and the initiator side of the program ROM interface. It owns the program counter, drives the 4-bit ROM address and captures the 16-bit instruction into an instruction register. It hands instructions to the decode stage over a valid/ready handshake and accepts jump/branch redirects and halt requests from execute. The ROM read is combinational: the instruction is available in the same cycle as the address.

---
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage and program ROM initiator
//
// Owns the program counter, drives a combinational ROM read and registers the
// returned instruction for the decode stage over a valid/ready handshake.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
//
// Ports:
//   clk            in   system clock, rising-edge state updates
//   rst            in   synchronous active-high reset
//   rom_addr       out  ROM address, equal to the program counter
//   rom_inst       in   ROM read data for rom_addr (same cycle)
//   start          in   leave IDLE/HALT and begin/resume fetching
//   halt_req       in   stop fetching and enter HALT
//   redirect_valid in   jump/branch taken this cycle
//   redirect_addr  in   jump/branch target
//   inst           out  registered instruction to decode
//   inst_pc        out  address inst was fetched from
//   inst_valid     out  inst/inst_pc hold a valid instruction
//   inst_ready     in   decode accepts inst when inst_valid=1
//   running        out  FSM in RUN
//   halted         out  FSM in HALT
//   fetch_count    out  captures performed (FETCH_PERF_CNT_EN only)
//   bubble_count   out  RUN cycles with no valid instruction (FETCH_PERF_CNT_EN only)

module fetch_unit #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned INST_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]       fetch_count,
  output logic [15:0]       bubble_count,
`endif
  output logic              running,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              running_q, halted_q;

  logic              transfer;
  logic              capture;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. halt_req always beats start.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && !halt_req) state_d = S_RUN;
      S_RUN:   if (halt_req)           state_d = S_HALT;
      S_HALT:  if (start && !halt_req) state_d = S_RUN;
      default:                         state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. A capture needs RUN, no halt or redirect this cycle, and room
  // in the instruction register (empty, or being drained by decode right now).
  // ---------------------------------------------------------------------------
  always_comb begin
    transfer = inst_valid_q && inst_ready;
    capture  = (state_q == S_RUN) && !halt_req && !redirect_valid &&
               (!inst_valid_q || inst_ready);
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    if (redirect_valid) begin
      // Flush: any transfer this cycle still completes, but nothing refills.
      pc_d         = redirect_addr;
      inst_valid_d = 1'b0;
    end else if (capture) begin
      inst_d       = rom_inst;
      inst_pc_d    = pc_q;
      inst_valid_d = 1'b1;
      pc_d         = pc_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
    end else if (transfer) begin
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= ADDR_W'(RESET_PC);
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      running_q    <= (state_d == S_RUN);
      halted_q     <= (state_d == S_HALT);
    end
  end

  assign rom_addr   = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign running    = running_q;
  assign halted     = halted_q;

`ifdef FETCH_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [15:0] fetch_count_q;
  logic [15:0] bubble_count_q;
  logic        bubble;

  assign bubble = (state_q == S_RUN) && !inst_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      if (capture && (fetch_count_q != 16'hFFFF)) begin
        fetch_count_q <= fetch_count_q + 16'd1;
      end
      if (bubble && (bubble_count_q != 16'hFFFF)) begin
        bubble_count_q <= bubble_count_q + 16'd1;
      end
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  rom_addr;
  logic [15:0] rom_inst;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [3:0]  redirect_addr;
  logic [15:0] inst;
  logic [3:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        running;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] bubble_count;
`endif

  logic [15:0] rom [16];
  int          errors;
  int          checks;

  fetch_unit #(
    .ADDR_W   (4),
    .INST_W   (16),
    .RESET_PC (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count),
`endif
    .running        (running),
    .halted         (halted)
  );

  assign rom_inst = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rom[0]  = 16'h1E08;
    rom[1]  = 16'h1201;
    rom[2]  = 16'h2202;
    rom[3]  = 16'h2303;
    rom[4]  = 16'h2404;
    rom[5]  = 16'h2505;
    rom[6]  = 16'h2606;
    rom[7]  = 16'h2707;
    rom[8]  = 16'h2808;
    rom[9]  = 16'h2909;
    rom[10] = 16'h3A0A;
    rom[11] = 16'h3B0B;
    rom[12] = 16'h3C0C;
    rom[13] = 16'h3D0D;
    rom[14] = 16'h3E0E;
    rom[15] = 16'h3F0F;

    rst = 1'b1; start = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 4'd0; inst_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid",   32'(inst_valid), 32'd0);
    check("rst_inst",    32'(inst),       32'd0);
    check("rst_inst_pc", 32'(inst_pc),    32'd0);
    check("rst_addr",    32'(rom_addr),   32'd0);
    check("rst_running", 32'(running),    32'd0);
    check("rst_halted",  32'(halted),     32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_fcnt", 32'(fetch_count),  32'd0);
    check("rst_bcnt", 32'(bubble_count), 32'd0);
`endif

    // IDLE does not fetch
    tick();
    check("idle_valid", 32'(inst_valid), 32'd0);
    check("idle_addr",  32'(rom_addr),   32'd0);

    // Start, first two fetches
    start = 1'b1; tick(); start = 1'b0;
    check("start_running", 32'(running),    32'd1);
    check("start_valid",   32'(inst_valid), 32'd0);
    tick();
    check("f0_inst",  32'(inst),       32'h1E08);
    check("f0_pc",    32'(inst_pc),    32'd0);
    check("f0_valid", 32'(inst_valid), 32'd1);
    tick();
    check("f1_inst", 32'(inst),     32'h1201);
    check("f1_pc",   32'(inst_pc),  32'd1);
    check("f1_addr", 32'(rom_addr), 32'd2);
    tick();
    check("f2_pc", 32'(inst_pc), 32'd2);

    // Backpressure for three cycles
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_pc",    32'(inst_pc),    32'd2);
      check("bp_inst",  32'(inst),       32'h2202);
      check("bp_valid", 32'(inst_valid), 32'd1);
      check("bp_addr",  32'(rom_addr),   32'd3);
    end
    inst_ready = 1'b1;
    tick();
    check("bp_rel_pc",   32'(inst_pc),  32'd3);
    check("bp_rel_addr", 32'(rom_addr), 32'd4);
    tick();
    check("pre_redir_addr", 32'(rom_addr), 32'd5);

    // Redirect to 10 from pc=5
    redirect_valid = 1'b1; redirect_addr = 4'd10; tick(); redirect_valid = 1'b0;
    check("redir_valid", 32'(inst_valid), 32'd0);
    check("redir_addr",  32'(rom_addr),   32'd10);
    tick();
    check("redir_pc",   32'(inst_pc), 32'd10);
    check("redir_inst", 32'(inst),    32'h3A0A);

    // Wrap 14, 15, 0, 1
    redirect_valid = 1'b1; redirect_addr = 4'd14; tick(); redirect_valid = 1'b0;
    check("wrap_flush", 32'(inst_valid), 32'd0);
    tick(); check("wrap_14", 32'(inst_pc), 32'd14);
    tick(); check("wrap_15", 32'(inst_pc), 32'd15);
    tick(); check("wrap_0",  32'(inst_pc), 32'd0);
    check("wrap_0_inst", 32'(inst), 32'h1E08);
    tick(); check("wrap_1",  32'(inst_pc), 32'd1);
    check("wrap_1_valid", 32'(inst_valid), 32'd1);

    // Halt at pc=7 with decode stalled
    redirect_valid = 1'b1; redirect_addr = 4'd6; tick(); redirect_valid = 1'b0;
    tick();
    check("h_setup_pc",   32'(inst_pc),  32'd6);
    check("h_setup_addr", 32'(rom_addr), 32'd7);
    inst_ready = 1'b0; halt_req = 1'b1; tick(); halt_req = 1'b0;
    check("h_halted",  32'(halted),     32'd1);
    check("h_running", 32'(running),    32'd0);
    check("h_valid",   32'(inst_valid), 32'd1);
    check("h_pc",      32'(inst_pc),    32'd6);
    check("h_addr",    32'(rom_addr),   32'd7);
    tick();
    check("h_hold_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1; tick();
    check("h_drain_valid", 32'(inst_valid), 32'd0);
    check("h_drain_addr",  32'(rom_addr),   32'd7);
    halt_req = 1'b1; start = 1'b1; tick(); halt_req = 1'b0; start = 1'b0;
    check("h_both_halted", 32'(halted),     32'd1);
    check("h_both_valid",  32'(inst_valid), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("resume_running", 32'(running), 32'd1);
    tick();
    check("resume_pc",   32'(inst_pc),    32'd7);
    check("resume_inst", 32'(inst),       32'h2707);
    check("resume_addr", 32'(rom_addr),   32'd8);

    // Halt and redirect together
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_addr = 4'd12; tick();
    halt_req = 1'b0; redirect_valid = 1'b0;
    check("hr_halted", 32'(halted),     32'd1);
    check("hr_valid",  32'(inst_valid), 32'd0);
    check("hr_addr",   32'(rom_addr),   32'd12);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("hr_resume_pc", 32'(inst_pc), 32'd12);
    tick();
    tick();
    tick();
    check("pre_rst_pc",    32'(inst_pc),    32'd15);
    redirect_valid = 1'b1; redirect_addr = 4'd8; tick(); redirect_valid = 1'b0;
    tick();
    check("pre_rst_valid", 32'(inst_valid), 32'd1);
    check("pre_rst_addr",  32'(rom_addr),   32'd9);

    // Reset mid-run
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_valid",   32'(inst_valid), 32'd0);
    check("mrst_addr",    32'(rom_addr),   32'd0);
    check("mrst_running", 32'(running),    32'd0);
    check("mrst_halted",  32'(halted),     32'd0);
    check("mrst_inst",    32'(inst),       32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("mrst_fcnt", 32'(fetch_count),  32'd0);
    check("mrst_bcnt", 32'(bubble_count), 32'd0);
`endif

    // Redirect in IDLE loads pc only
    redirect_valid = 1'b1; redirect_addr = 4'd3; tick(); redirect_valid = 1'b0;
    check("idle_redir_addr",    32'(rom_addr),   32'd3);
    check("idle_redir_valid",   32'(inst_valid), 32'd0);
    check("idle_redir_running", 32'(running),    32'd0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("idle_redir_pc",   32'(inst_pc), 32'd3);
    check("idle_redir_inst", 32'(inst),    32'h2303);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fcnt", 32'(fetch_count),  32'd1);
    check("perf_bcnt", 32'(bubble_count), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
